// File: rtl/display_decoder.sv
// Registered hex to seven-segment decoder, one digit.
// Segment order on out is a..g from bit 6 down to bit 0.
module display_decoder #(
  parameter logic SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic [3:0] num,
  input  logic       rst,
  output logic [6:0] out
);

  localparam logic [6:0] POL = {7{SEG_ACTIVE_LOW}};

  logic [6:0] seg;
  logic [6:0] out_q = POL;

  // hex digit to active-high abcdefg pattern; unknown codes blank
  always_comb begin
    seg = 7'b0000000;
    case (num)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
  end

  // pin register: reset blanks, otherwise load the polarity-adjusted pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= POL;
    end else begin
      out_q <= seg ^ POL;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_display_decoder.sv
// Self-checking bench for display_decoder, both segment polarities.
// Vector table, hand sequences and random stimulus against a set-based model.
module tb_display_decoder;

  logic       clk = 1'b0;
  logic [3:0] num = 4'h0;
  logic       rst = 1'b0;
  logic [6:0] oh;
  logic [6:0] ol;

  int errors = 0;
  int checks = 0;

  display_decoder #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .num(num), .rst(rst), .out(oh)
  );

  display_decoder #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .num(num), .rst(rst), .out(ol)
  );

  always #5 clk = ~clk;

  // each segment is lit unless the digit is in its "dark" set
  function automatic logic [6:0] model(input logic [3:0] n, input logic low);
    logic [6:0] s;
    int v;
    v = int'(n);
    s[6] = !(v inside {1, 4, 11, 13});
    s[5] = !(v inside {5, 6, 11, 12, 14, 15});
    s[4] = !(v inside {2, 12, 14, 15});
    s[3] = !(v inside {1, 4, 7, 10, 15});
    s[2] = !(v inside {1, 3, 4, 5, 7, 9});
    s[1] = !(v inside {1, 2, 3, 7, 13});
    s[0] = !(v inside {0, 1, 7, 12});
    return low ? ~s : s;
  endfunction

  task automatic chk(input string name, input logic [6:0] act,
                     input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] n, input logic r);
    @(negedge clk);
    num = n;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic [3:0] n;
    logic [6:0] e;
  } vec_t;

  vec_t tbl[$];
  logic [3:0] v;
  logic       r;
  logic [6:0] e;

  initial begin
    // reset and release (digit 8)
    tbl.push_back('{1'b1, 4'h8, 7'b0000000});
    tbl.push_back('{1'b1, 4'h8, 7'b0000000});
    tbl.push_back('{1'b0, 4'h8, 7'b1111111});
    // full sweep with the literal segment table
    tbl.push_back('{1'b0, 4'h0, 7'b1111110});
    tbl.push_back('{1'b0, 4'h1, 7'b0110000});
    tbl.push_back('{1'b0, 4'h2, 7'b1101101});
    tbl.push_back('{1'b0, 4'h3, 7'b1111001});
    tbl.push_back('{1'b0, 4'h4, 7'b0110011});
    tbl.push_back('{1'b0, 4'h5, 7'b1011011});
    tbl.push_back('{1'b0, 4'h6, 7'b1011111});
    tbl.push_back('{1'b0, 4'h7, 7'b1110000});
    tbl.push_back('{1'b0, 4'h8, 7'b1111111});
    tbl.push_back('{1'b0, 4'h9, 7'b1111011});
    tbl.push_back('{1'b0, 4'hA, 7'b1110111});
    tbl.push_back('{1'b0, 4'hB, 7'b0011111});
    tbl.push_back('{1'b0, 4'hC, 7'b1001110});
    tbl.push_back('{1'b0, 4'hD, 7'b0111101});
    tbl.push_back('{1'b0, 4'hE, 7'b1001111});
    tbl.push_back('{1'b0, 4'hF, 7'b1000111});
    // wrap, then reset mid-sweep and resume
    tbl.push_back('{1'b0, 4'h0, 7'b1111110});
    tbl.push_back('{1'b0, 4'h1, 7'b0110000});
    tbl.push_back('{1'b0, 4'h2, 7'b1101101});
    tbl.push_back('{1'b1, 4'h3, 7'b0000000});
    tbl.push_back('{1'b0, 4'h5, 7'b1011011});

    // power-up value before any edge
    #1;
    chk("powerup_hi", oh, 7'b0000000);
    chk("powerup_lo", ol, 7'b1111111);

    foreach (tbl[i]) begin
      step(tbl[i].n, tbl[i].r);
      chk($sformatf("vec%0d_hi", i), oh, tbl[i].e);
      chk($sformatf("vec%0d_lo", i), ol, tbl[i].e ^ 7'h7f);
    end

    // active-low corner values
    step(4'h0, 1'b1);
    chk("lo_reset", ol, 7'b1111111);
    step(4'h0, 1'b0);
    chk("lo_digit0", ol, 7'b0000001);
    step(4'hF, 1'b0);
    chk("lo_digitF", ol, 7'b0111000);

    // num changes twice per cycle; only the value at the rising edge counts
    v = 4'hB;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      num = v;
      e = model(v, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("dual%0d_hi", i), oh, e);
      #1;
      num = v + 4'h1;
      @(negedge clk);
      chk($sformatf("dual%0d_mid", i), oh, e);
      v = v + 4'h2;
    end

    // wrap F->0 with the digit set on the edge side
    step(4'hF, 1'b0);
    step(4'h0, 1'b0);
    chk("wrap_F0", oh, 7'b1111110);

    // hold A for ten edges, watching mid-cycle too
    for (int i = 0; i < 10; i++) begin
      step(4'hA, 1'b0);
      chk($sformatf("holdA%0d", i), oh, 7'b1110111);
      @(negedge clk);
      chk($sformatf("holdA%0d_mid", i), oh, 7'b1110111);
    end

    // random digits with occasional reset
    for (int i = 0; i < 300; i++) begin
      v = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 9) == 0);
      step(v, r);
      if (r) begin
        chk($sformatf("rnd%0d_rst_hi", i), oh, 7'b0000000);
        chk($sformatf("rnd%0d_rst_lo", i), ol, 7'b1111111);
      end else begin
        chk($sformatf("rnd%0d_hi", i), oh, model(v, 1'b0));
        chk($sformatf("rnd%0d_lo", i), ol, model(v, 1'b1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
